uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver; next generation of the fixed 8N1 uart_rx.
//  Adds configurable payload width, parity and stop bits, 3-sample majority voting,
//  false-start rejection, parity/framing error flags and an optional receive FIFO.
//  Sits between the uart_rxd pad and the host bus or stream logic.
// PARAMETERS
//  CLK_HZ        48000000  system clock frequency, Hz
//  BIT_RATE      9600      line rate, bit/s; CPB = CLK_HZ/BIT_RATE cycles per bit (CPB >= 8)
//  PAYLOAD_BITS  8         data bits per frame, 5..9, sent LSB first
//  PARITY        0         0 = none, 1 = even, 2 = odd
//  STOP_BITS     1         1 or 2
//  FIFO_DEPTH    8         entries, power of 2 (used only with UART_RX_FIFO_EN)
// PORTS
//  clk            in   1             system clock
//  resetn         in   1             asynchronous, active-low reset
//  uart_rxd       in   1             serial line, idles high, asynchronous to clk
//  uart_rx_en     in   1             receive enable
//  uart_rx_ready  in   1             consumer ready (FIFO build only; ignored otherwise)
//  uart_rx_valid  out  1             data/flags valid
//  uart_rx_data   out  PAYLOAD_BITS  received payload
//  uart_rx_perr   out  1             parity error, qualified by uart_rx_valid
//  uart_rx_ferr   out  1             framing error (stop bit sampled 0), qualified by valid
//  uart_rx_break  out  1             1-cycle pulse: break condition detected
//  uart_rx_overrun out 1             sticky: frame dropped because FIFO full
// BEHAVIOUR
//  - Reset: all outputs 0, uart_rx_data 0, FSM IDLE, synchroniser flops = 1, FIFO empty.
//  - uart_rxd passes through a 2-FF synchroniser; all logic uses the synchronised value.
//  - Bit timer counts 0..CPB-1. Samples taken at CPB/2-1, CPB/2 and CPB/2+1;
//    bit value = majority of 3.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> (IDLE | WAIT_HIGH).
//    IDLE:  falling edge while uart_rx_en = 1 -> START, timer cleared.
//    START: majority at mid-bit = 1 -> false start, back to IDLE, no output.
//    DATA:  PAYLOAD_BITS bits shifted in LSB first.
//    PARITY (PARITY != 0): the received bit is compared with the even/odd parity
//      of the data; a mismatch sets perr.
//    STOP:  STOP_BITS bits sampled; any 0 sets ferr.
//  - Break: start bit, all data bits, parity bit and the first stop bit all 0.
//    Result: uart_rx_break pulses 1 cycle, no data word is produced, FSM -> WAIT_HIGH.
//  - WAIT_HIGH: stays until the synchronised line is 1, then -> IDLE.
//  - Result timing: registered, 1 cycle after the mid-sample of the last stop bit.
//    Next start edge is accepted from that same cycle, so back-to-back frames are supported.
//  - uart_rx_en low mid-frame: abort to IDLE immediately; no output for that frame.
//  - A frame with ferr and/or perr is still delivered; its flags are set.
// CONFIGURATION
//  UART_RX_FIFO_EN defined:
//    - Each frame pushes {perr, ferr, data} into a FIFO_DEPTH-entry FIFO.
//    - uart_rx_valid = FIFO not empty; outputs show the head entry.
//    - Pop on valid & ready.
//    - Push while full with no pop: frame dropped, uart_rx_overrun set. Overrun clears
//      on the next pop.
//    - Push and pop in the same cycle while full: both succeed, no overrun.
//  UART_RX_FIFO_EN undefined:
//    - uart_rx_valid is a 1-cycle pulse per frame; data and flags hold until the next frame.
//    - uart_rx_ready ignored; uart_rx_overrun tied 0.
// TESTING (defaults, CPB = 5000)
//  1. Send 8N1 0xA5 -> one valid, data = 0xA5, perr = ferr = 0.
//  2. PARITY = 1: send 0x3C with parity bit 1 -> data 0x3C, perr = 1.
//     Same frame with parity bit 0 -> perr = 0.
//  3. Send 0x5A with stop bit 0, then line high -> data 0x5A, ferr = 1, break = 0.
//  4. Line low for 12 bit times -> one break pulse, no valid.
//     After line returns high, 0x81 is received correctly.
//  5. Low glitch of 2000 cycles while idle -> no valid.
//     1-cycle glitch at a data mid-sample -> bit value unchanged (majority vote).
//  6. FIFO build: ready = 0, send 9 frames 0x01..0x09 -> overrun = 1.
//     Then ready = 1 -> pops 0x01..0x08 in order; overrun clears on the first pop.

Source files
------------

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with majority voting, error flags and optional FIFO
// Optional receive FIFO is built when UART_RX_FIFO_EN is defined.
module uart_rx_param #(
    parameter int CLK_HZ       = 48000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    input  logic                    uart_rx_ready,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_perr,
    output logic                    uart_rx_ferr,
    output logic                    uart_rx_break,
    output logic                    uart_rx_overrun
);
    localparam int CPB  = CLK_HZ / BIT_RATE;
    localparam int TW   = $clog2(CPB);
    localparam int HALF = CPB / 2;
    localparam logic [TW-1:0] T_S0      = TW'(HALF - 1);
    localparam logic [TW-1:0] T_S1      = TW'(HALF);
    localparam logic [TW-1:0] T_MID     = TW'(HALF + 1);
    localparam logic [TW-1:0] T_END     = TW'(CPB - 1);
    localparam logic [3:0]    LAST_DATA = 4'(PAYLOAD_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t                    r_state, w_state_next;
    logic                      r_sync1, r_sync2, r_sync_prev;
    logic [TW-1:0]             r_timer;
    logic                      r_samp0, r_samp1;
    logic [3:0]                r_bit_idx;
    logic                      r_stop_idx;
    logic [PAYLOAD_BITS-1:0]   r_shift;
    logic                      r_all_zero, r_perr_acc, r_ferr_acc;
    logic                      r_break;
    logic                      w_rxd, w_fall, w_mid, w_end, w_maj, w_par_exp;
    logic                      w_deliver, w_break;
    logic [PAYLOAD_BITS+1:0]   w_frame;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_prev <= 1'b1;
        end else begin
            r_sync1     <= uart_rxd;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    assign w_rxd     = r_sync2;
    assign w_fall    = r_sync_prev & ~r_sync2;
    assign w_mid     = (r_timer == T_MID);
    assign w_end     = (r_timer == T_END);
    // The third vote is the live synchronised line at the decision cycle.
    assign w_maj     = (r_samp0 & r_samp1) | (r_samp0 & w_rxd) | (r_samp1 & w_rxd);
    assign w_par_exp = (PARITY == 2) ? ~(^r_shift) : (^r_shift);
    assign w_frame   = {r_perr_acc, r_ferr_acc | ~w_maj, r_shift};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_deliver    = 1'b0;
        w_break      = 1'b0;
        if (!uart_rx_en && r_state != S_IDLE) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:      if (uart_rx_en && w_fall) w_state_next = S_START;
                S_START: begin
                    if (w_mid && w_maj) w_state_next = S_IDLE;
                    else if (w_end)     w_state_next = S_DATA;
                end
                S_DATA: begin
                    if (w_end && r_bit_idx == LAST_DATA)
                        w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                end
                S_PARITY:    if (w_end) w_state_next = S_STOP;
                S_STOP: begin
                    if (w_mid) begin
                        if (!r_stop_idx && !w_maj && r_all_zero) begin
                            w_break      = 1'b1;
                            w_state_next = S_WAIT_HIGH;
                        end else if (r_stop_idx == LAST_STOP) begin
                            w_deliver    = 1'b1;
                            w_state_next = S_IDLE;
                        end
                    end
                end
                S_WAIT_HIGH: if (w_rxd) w_state_next = S_IDLE;
                default:     w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer    <= '0;
            r_samp0    <= 1'b1;
            r_samp1    <= 1'b1;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_all_zero <= 1'b0;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_break    <= 1'b0;
        end else begin
            r_break <= w_break;
            if (r_state == S_IDLE || w_state_next == S_IDLE || w_state_next == S_WAIT_HIGH || w_end)
                r_timer <= '0;
            else
                r_timer <= r_timer + TW'(1);
            if (r_timer == T_S0) r_samp0 <= w_rxd;
            if (r_timer == T_S1) r_samp1 <= w_rxd;
            case (r_state)
                S_IDLE: begin
                    r_bit_idx  <= '0;
                    r_stop_idx <= 1'b0;
                    r_all_zero <= 1'b1;
                    r_perr_acc <= 1'b0;
                    r_ferr_acc <= 1'b0;
                end
                S_DATA: begin
                    if (w_mid) begin
                        r_shift <= {w_maj, r_shift[PAYLOAD_BITS-1:1]};
                        if (w_maj) r_all_zero <= 1'b0;
                    end
                    if (w_end) r_bit_idx <= r_bit_idx + 4'd1;
                end
                S_PARITY: begin
                    if (w_mid) begin
                        r_perr_acc <= w_maj ^ w_par_exp;
                        if (w_maj) r_all_zero <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (w_mid && !w_maj) r_ferr_acc <= 1'b1;
                    if (w_end)           r_stop_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign uart_rx_break = r_break;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [PAYLOAD_BITS+1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]             r_wr_ptr, r_rd_ptr;
    logic                    r_overrun;
    logic                    w_empty, w_full, w_pop, w_push;
    logic [PAYLOAD_BITS+1:0] w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && uart_rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
    assign w_push  = w_deliver && (!w_full || w_pop);
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_frame;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_pop)                        r_overrun <= 1'b0;
            else if (w_deliver && w_full)     r_overrun <= 1'b1;
        end
    end

    assign uart_rx_valid   = !w_empty;
    assign uart_rx_data    = w_empty ? '0 : w_head[PAYLOAD_BITS-1:0];
    assign uart_rx_ferr    = !w_empty && w_head[PAYLOAD_BITS];
    assign uart_rx_perr    = !w_empty && w_head[PAYLOAD_BITS+1];
    assign uart_rx_overrun = r_overrun;
`else
    logic                    r_valid, r_perr, r_ferr;
    logic [PAYLOAD_BITS-1:0] r_data;
    logic                    w_unused;

    assign w_unused = uart_rx_ready & (FIFO_DEPTH > 0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= w_deliver;
            if (w_deliver) begin
                r_data <= w_frame[PAYLOAD_BITS-1:0];
                r_ferr <= w_frame[PAYLOAD_BITS];
                r_perr <= w_frame[PAYLOAD_BITS+1];
            end
        end
    end

    assign uart_rx_valid   = r_valid;
    assign uart_rx_data    = r_data;
    assign uart_rx_perr    = r_perr;
    assign uart_rx_ferr    = r_ferr;
    assign uart_rx_overrun = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed self-checking bench for uart_rx_param (CPB = 16)
module tb_uart_rx_param;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       resetn, rxd, rxd_p, rx_en, rx_ready;
    logic       valid, perr, ferr, brk, ovr;
    logic [7:0] data;
    logic       valid_p, perr_p, ferr_p, brk_p, ovr_p;
    logic [7:0] data_p;

    int n_checks = 0;
    int n_errors = 0;
    int nbrk0 = 0;
    int nbrk_snap;
    logic [9:0] q0[$];
    logic [9:0] q1[$];

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_HZ(160), .BIT_RATE(10), .PAYLOAD_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(8)) u_dut (
        .clk(clk), .resetn(resetn), .uart_rxd(rxd), .uart_rx_en(rx_en),
        .uart_rx_ready(rx_ready), .uart_rx_valid(valid), .uart_rx_data(data),
        .uart_rx_perr(perr), .uart_rx_ferr(ferr), .uart_rx_break(brk),
        .uart_rx_overrun(ovr));

    uart_rx_param #(.CLK_HZ(160), .BIT_RATE(10), .PAYLOAD_BITS(8), .PARITY(1),
                    .STOP_BITS(1), .FIFO_DEPTH(8)) u_dut_par (
        .clk(clk), .resetn(resetn), .uart_rxd(rxd_p), .uart_rx_en(rx_en),
        .uart_rx_ready(rx_ready), .uart_rx_valid(valid_p), .uart_rx_data(data_p),
        .uart_rx_perr(perr_p), .uart_rx_ferr(ferr_p), .uart_rx_break(brk_p),
        .uart_rx_overrun(ovr_p));

    always @(negedge clk) begin
        if (valid && rx_ready)     q0.push_back({perr, ferr, data});
        if (valid_p && rx_ready)   q1.push_back({perr_p, ferr_p, data_p});
        if (brk)                   nbrk0++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rxd = v;
        else          rxd_p = v;
    endtask

    task automatic send_bit(input int sel, input logic v, input logic glitch);
        for (int c = 0; c < CPB; c++) begin
            drive(sel, (glitch && c == 9) ? ~v : v);
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input int par,
                              input logic stop, input int gbit);
        send_bit(sel, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i], i == gbit);
        if (par >= 0) send_bit(sel, par[0], 1'b0);
        send_bit(sel, stop, 1'b0);
        drive(sel, 1'b1);
    endtask

    task automatic idle_bits(input int n);
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic expect_one(input int sel, input string tag, input logic [9:0] exp);
        if (sel == 0) begin
            check({tag, "_count"}, q0.size(), 1);
            if (q0.size() != 0) check(tag, {22'd0, q0.pop_front()}, {22'd0, exp});
            q0.delete();
        end else begin
            check({tag, "_count"}, q1.size(), 1);
            if (q1.size() != 0) check(tag, {22'd0, q1.pop_front()}, {22'd0, exp});
            q1.delete();
        end
    endtask

    initial begin
        resetn = 1'b0; rxd = 1'b1; rxd_p = 1'b1; rx_en = 1'b1; rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_data",  data, 0);
        check("rst_perr",  perr, 0);
        check("rst_ferr",  ferr, 0);
        check("rst_break", brk, 0);
        check("rst_overrun", ovr, 0);
        resetn = 1'b1;
        idle_bits(2);

        send_frame(0, 8'hA5, -1, 1'b1, -1);
        idle_bits(1);
        expect_one(0, "8n1_a5", 10'h0A5);

        send_frame(1, 8'h3C, 1, 1'b1, -1);
        idle_bits(1);
        expect_one(1, "par_3c_bad", 10'h23C);
        send_frame(1, 8'h3C, 0, 1'b1, -1);
        idle_bits(1);
        expect_one(1, "par_3c_good", 10'h03C);
        send_frame(1, 8'h07, 1, 1'b1, -1);
        idle_bits(1);
        expect_one(1, "par_07_good", 10'h007);

        nbrk_snap = nbrk0;
        send_frame(0, 8'h5A, -1, 1'b0, -1);
        idle_bits(1);
        expect_one(0, "ferr_5a", 10'h15A);
        check("ferr_no_break", nbrk0 - nbrk_snap, 0);

        nbrk_snap = nbrk0;
        drive(0, 1'b0);
        idle_bits(12);
        drive(0, 1'b1);
        idle_bits(2);
        check("break_pulses", nbrk0 - nbrk_snap, 1);
        check("break_no_valid", q0.size(), 0);
        q0.delete();
        send_frame(0, 8'h81, -1, 1'b1, -1);
        idle_bits(1);
        expect_one(0, "after_break_81", 10'h081);

        drive(0, 1'b0);
        repeat (5) @(negedge clk);
        drive(0, 1'b1);
        idle_bits(12);
        check("false_start_no_valid", q0.size(), 0);
        q0.delete();

        send_frame(0, 8'hC3, -1, 1'b1, 0);
        idle_bits(1);
        expect_one(0, "glitch_bit0_c3", 10'h0C3);
        send_frame(0, 8'h3C, -1, 1'b1, 4);
        idle_bits(1);
        expect_one(0, "glitch_bit4_3c", 10'h03C);

        send_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) rx_en = 1'b0;
            send_bit(0, 8'h0F >> i, 1'b0);
        end
        send_bit(0, 1'b1, 1'b0);
        rx_en = 1'b1;
        idle_bits(2);
        check("abort_no_valid", q0.size(), 0);
        q0.delete();
        send_frame(0, 8'h42, -1, 1'b1, -1);
        idle_bits(1);
        expect_one(0, "after_abort_42", 10'h042);

        send_frame(0, 8'h11, -1, 1'b1, -1);
        send_frame(0, 8'h22, -1, 1'b1, -1);
        idle_bits(1);
        check("b2b_count", q0.size(), 2);
        if (q0.size() == 2) begin
            check("b2b_first",  {22'd0, q0[0]}, 32'h011);
            check("b2b_second", {22'd0, q0[1]}, 32'h022);
        end
        q0.delete();

`ifdef UART_RX_FIFO_EN
        rx_ready = 1'b0;
        for (int f = 1; f <= 9; f++) begin
            send_frame(0, 8'(f), -1, 1'b1, -1);
            idle_bits(1);
        end
        check("fifo_overrun_set", ovr, 1);
        check("fifo_valid_held", valid, 1);
        check("fifo_head_01", data, 8'h01);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("fifo_overrun_clear", ovr, 0);
        idle_bits(1);
        check("fifo_pop_count", q0.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < q0.size()) check($sformatf("fifo_pop_%0d", k), {22'd0, q0[k]}, k + 1);
        end
        check("fifo_empty", valid, 0);
        q0.delete();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
